// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: write-back arbiter for the integer register file write port.
// Two producers (port 0 = execute, port 1 = load/memory) compete through
// valid/ready handshakes. The winner is registered and presented to the
// register file one cycle after acceptance. A saturating counter records the
// number of cycles in which both producers were requesting.
// Optional feature macro: WB_RR_EN selects round-robin arbitration. When it is
// undefined, port 1 always wins a conflict.
module reg_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              grant0;
  logic              grant1;
  logic              both_valid;
  logic              acc0;
  logic              acc1;

  logic              we_q,   we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  assign both_valid = req0_valid & req1_valid;

`ifdef WB_RR_EN
  // Index of the port granted in the most recent conflict; 1 after reset so
  // that port 0 wins the first conflict.
  logic last_q, last_d;

  // Grant selection: a lone request wins; on a conflict the port that did
  // not win last time is chosen.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (both_valid) begin
      if (last_q) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Priority state advances only on conflict cycles while the pipeline runs.
  always_comb begin
    last_d = last_q;
    if (rdy && both_valid) begin
      last_d = grant1;
    end
  end

  // Priority state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Grant selection: a lone request wins; the load port wins every conflict.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (both_valid) begin
      grant1 = 1'b1;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end
`endif

  assign req0_ready = grant0 & rdy & ~rst;
  assign req1_ready = grant1 & rdy & ~rst;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;

  // Next-state for the write port and conflict counter; everything holds
  // while rdy is low, including write_enable.
  always_comb begin
    we_d   = we_q;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (rdy) begin
      we_d = 1'b0;
      if (acc0) begin
        addr_d = req0_addr;
        data_d = req0_data;
        we_d   = |req0_addr;  // x0 writes are consumed but never enabled
      end else if (acc1) begin
        addr_d = req1_addr;
        data_d = req1_data;
        we_d   = |req1_addr;
      end
      if (both_valid && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Output and counter registers; reset discards any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign write_enable = we_q;
  assign write_addr   = addr_q;
  assign write_data   = data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Testbench for reg_wb_arbiter. Directed scenarios followed by randomized
// producers that hold requests until accepted. A reference model predicts the
// readies each cycle and the registered outputs of the following cycle; the
// expected outputs go into a queue that a separate monitor drains and compares.
// Build with or without WB_RR_EN to match the design.
module tb_reg_wb_arbiter;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic              req0_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [DATA_W-1:0] req0_data = '0;
  logic              req0_ready;
  logic              req1_valid = 1'b0;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [DATA_W-1:0] req1_data = '0;
  logic              req1_ready;
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [CNT_W-1:0]  conflict_cnt;

  reg_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                due;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: what the register file port should show.
  logic              m_we   = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_cnt  = 0;
  int                m_last = 1;   // port granted in the latest conflict

  // Drive one cycle of inputs, check the readies against the model, push the
  // expected outputs for after the coming edge, then advance one cycle.
  task automatic step(input logic v0, input logic [ADDR_W-1:0] a0,
                      input logic [DATA_W-1:0] d0,
                      input logic v1, input logic [ADDR_W-1:0] a1,
                      input logic [DATA_W-1:0] d1,
                      input logic r, input logic s,
                      output logic acc0, output logic acc1);
    int   winner;
    exp_t e;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    rdy = r; rst = s;
    #1;
    // Which port the rules say should win (-1 for none).
    winner = -1;
    if (v0 && v1) begin
`ifdef WB_RR_EN
      winner = 1 - m_last;
`else
      winner = 1;
`endif
    end else if (v0) winner = 0;
    else if (v1) winner = 1;
    acc0 = (winner == 0) && r && !s;
    acc1 = (winner == 1) && r && !s;
    checks++;
    if (req0_ready !== acc0) begin
      errors++;
      $display("FAIL req0_ready cyc=%0d got=%b exp=%b", cyc, req0_ready, acc0);
    end
    checks++;
    if (req1_ready !== acc1) begin
      errors++;
      $display("FAIL req1_ready cyc=%0d got=%b exp=%b", cyc, req1_ready, acc1);
    end
    if (s) begin
      m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0; m_last = 1;
    end else if (r) begin
      m_we = 1'b0;
      if (acc0) begin m_addr = a0; m_data = d0; m_we = (a0 != 0); end
      if (acc1) begin m_addr = a1; m_data = d1; m_we = (a1 != 0); end
      if (v0 && v1) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        m_last = winner;
      end
    end
    e.due = cyc + 1; e.we = m_we; e.addr = m_addr; e.data = m_data; e.cnt = m_cnt;
    exp_q.push_back(e);
    $display("cyc=%0d rst=%b rdy=%b v0=%b a0=%0d v1=%b a1=%0d -> acc0=%b acc1=%b",
             cyc, s, r, v0, a0, v1, a1, acc0, acc1);
    @(posedge clk); #1;
  endtask

  // Monitor: after every edge, compare the presented outputs with the entry
  // due for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #3;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        errors++; checks++;
        $display("FAIL stale_entry cyc=%0d got=none exp_due=%0d", cyc, e.due);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (write_enable !== e.we) begin
          errors++;
          $display("FAIL write_enable cyc=%0d got=%b exp=%b", cyc, write_enable, e.we);
        end
        checks++;
        if (write_addr !== e.addr) begin
          errors++;
          $display("FAIL write_addr cyc=%0d got=%0d exp=%0d", cyc, write_addr, e.addr);
        end
        checks++;
        if (write_data !== e.data) begin
          errors++;
          $display("FAIL write_data cyc=%0d got=%h exp=%h", cyc, write_data, e.data);
        end
        checks++;
        if (conflict_cnt !== CNT_W'(e.cnt)) begin
          errors++;
          $display("FAIL conflict_cnt cyc=%0d got=%0d exp=%0d", cyc, conflict_cnt, e.cnt);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic              a0, a1;
    logic              p0v, p1v;
    logic [ADDR_W-1:0] p0a, p1a;
    logic [DATA_W-1:0] p0d, p1d;
    int                guard;
    @(posedge clk); #1;

    // Reset held for two cycles with both producers requesting.
    for (int i = 0; i < 2; i++)
      step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 1'b1, a0, a1);

    // Single request on port 0, then idle.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, a0, a1);
    step(1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, a0, a1);
    step(1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, a0, a1);

    // Both ports held valid for four cycles; each accepted request is
    // replaced by a fresh one to the same register.
    p0d = 32'h100; p1d = 32'h200;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd1, p0d, 1'b1, 5'd2, p1d, 1'b1, 1'b0, a0, a1);
      if (a0) p0d++;
      if (a1) p1d++;
    end
    // Load port drops; execute port must drain.
    guard = 0;
    do begin
      step(1'b1, 5'd1, p0d, 1'b0, 5'd2, p1d, 1'b1, 1'b0, a0, a1);
      guard++;
    end while (!a0 && guard < 4);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, a0, a1);

    // Write to x0 is accepted but does not enable the register file.
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b1, 1'b0, a0, a1);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h1234, 1'b1, 1'b0, a0, a1);

    // Stall: a pending request waits through three rdy-low cycles.
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd7, 32'hCAFE0007, 1'b1, 5'd9, 32'h9, 1'b0, 1'b0, a0, a1);
    step(1'b1, 5'd7, 32'hCAFE0007, 1'b0, 5'd9, 32'h9, 1'b1, 1'b0, a0, a1);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, a0, a1);

    // Randomized producers that hold each request until it is accepted.
    p0v = 1'b0; p1v = 1'b0; p0a = '0; p1a = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!p0v && $urandom_range(0, 2) != 0) begin
        p0v = 1'b1;
        p0a = ($urandom_range(0, 7) == 0) ? 5'd0 : ADDR_W'($urandom);
        p0d = $urandom;
      end
      if (!p1v && $urandom_range(0, 2) != 0) begin
        p1v = 1'b1;
        p1a = ($urandom_range(0, 7) == 0) ? 5'd0 : ADDR_W'($urandom);
        p1d = $urandom;
      end
      step(p0v, p0a, p0d, p1v, p1a, p1d,
           ($urandom_range(0, 4) != 0), ($urandom_range(0, 59) == 0), a0, a1);
      if (a0) p0v = 1'b0;
      if (a1) p1v = 1'b0;
    end

    // Drain and finish.
    for (int i = 0; i < 2; i++)
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, a0, a1);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk); #4;
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter for the single write port of the integer register file. Two producers share the port through valid/ready handshakes: the execute stage (port 0) and the load/memory stage (port 1). The block registers the winning request and drives the register file's write_enable/write_addr/write_data one cycle later. It also keeps a saturating conflict counter for performance monitoring.

## Interface
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- CNT_W, 16, conflict counter width

- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- rdy  input  1  global ready; low freezes all state
- req0_valid  input  1  execute-stage write request
- req0_addr  input  ADDR_W  destination register
- req0_data  input  DATA_W  write value
- req0_ready  output  1  request 0 accepted this cycle
- req1_valid / req1_addr / req1_data  input  1 / ADDR_W / DATA_W  load-stage request
- req1_ready  output  1  request 1 accepted this cycle
- write_enable  output  1  to register file
- write_addr  output  ADDR_W  to register file
- write_data  output  DATA_W  to register file
- conflict_cnt  output  CNT_W  cycles with both requests valid, saturating

## Operation
- Grant is combinational from req*_valid and the priority state. At most one reqN_ready is high per cycle.
- reqN_ready = grantN & rdy & ~rst. A request is accepted when reqN_valid & reqN_ready.
- Producers hold valid, addr and data stable until accepted. A losing requester waits; it is never dropped.
- On acceptance, write_addr and write_data register the winner's addr and data. write_enable registers 1, except for addr 0: an x0 write is accepted and consumed, but write_enable registers 0.
- Cycle with no acceptance: write_enable registers 0; write_addr and write_data hold their previous values.
- conflict_cnt increments on every cycle with rdy=1 and both valids high. It saturates at 2^CNT_W-1.
- Priority state `last` is 1 bit, meaning the last granted port. It updates only on a cycle where both requests are valid (used only when the round-robin feature is compiled in).

## Timing
- Reset values: write_enable=0, write_addr=0, write_data=0, conflict_cnt=0, last=1 (port 0 wins the first conflict). During rst, req0_ready=req1_ready=0.
- Latency: an acceptance in cycle N gives write_enable=1 in cycle N+1, for exactly one cycle per accepted request.
- Throughput is one write per cycle. Back-to-back acceptances give back-to-back write_enable pulses.
- When rdy=0: both readies are 0, and all registers (write_enable, write_addr, write_data, conflict_cnt, last) hold. write_enable stays at its prior value, so the register file must gate with rdy.
- rst asserted mid-stream: in-flight accepted data is discarded. The next cycle shows write_enable=0, and producers re-present.
- A request asserted in the same cycle it is granted is accepted in that cycle; there is no bubble.

## Configuration
- Macro: WB_RR_EN.
- When defined: round-robin arbitration. On conflict, the port other than `last` wins, and `last` toggles to the winner.
- When undefined: fixed priority, port 1 (load) always wins a conflict. `last` is not implemented. conflict_cnt behaves the same in both builds.
- A single valid request is granted immediately in both builds.

## Test plan
- Reset: assert rst 2 cycles with both valids high -> readies 0, write_enable 0, conflict_cnt 0.
- Single request: req0 addr 5, data 0xDEADBEEF for 1 cycle -> req0_ready=1; next cycle write_enable=1, write_addr=5, write_data=0xDEADBEEF; the following cycle write_enable=0.
- Conflict, WB_RR_EN defined: both valid for 4 cycles (req0 addr 1, req1 addr 2) -> writes 1,2 then the next pair in alternating order; conflict_cnt counts each cycle both were valid.
- Conflict, WB_RR_EN undefined: both held valid -> req1 granted every cycle and req0 starves until req1_valid drops; then req0 is written 1 cycle later.
- x0 drop: req1 addr 0, data 0x1234 -> req1_ready=1, next-cycle write_enable=0.
- rdy stall: pending req0 with rdy=0 for 3 cycles -> readies 0, outputs and conflict_cnt frozen; rdy=1 -> accepted, write 1 cycle later.
